muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//   Multi-cycle sequencer for the EX-stage mult/div path. It is started by ALU
//   control codes 4'b1010 (mult) and 4'b1011 (div). It runs a radix-2 shift-add
//   multiply or restoring divide over WIDTH cycles and owns the HI/LO registers.
//   It asserts stall to the pipeline hazard unit while a HI/LO result is pending.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO width; iteration count per operation
// PORTS
//   clk       in   1       clock; all state changes on the rising edge
//   reset_n   in   1       synchronous, active-low reset
//   start     in   1       EX holds a mult/div instruction this cycle
//   alucontrol in  4       4'b1010 = mult, 4'b1011 = div; other codes ignored
//   srca      in   WIDTH   multiplicand / dividend
//   srcb      in   WIDTH   multiplier / divisor
//   hilo_rd   in   1       an instruction reading HI or LO (mfhi/mflo) is in EX
//   flush     in   1       abort the in-flight operation (branch/exception kill)
//   busy      out  1       state is MUL or DIV
//   stall     out  1       busy & (start | hilo_rd); combinational
//   done      out  1       one-cycle pulse: HI/LO were just written
//   hi        out  WIDTH   HI register (product high half / remainder)
//   lo        out  WIDTH   LO register (product low half / quotient)
// BEHAVIOUR
//   Reset: state=IDLE, count=0, hi=lo=0, done=0, busy=0, stall=0.
//   States: IDLE, MUL, DIV, DONE.
//   - IDLE/DONE: start & code 1010 -> MUL; start & code 1011 -> DIV. The
//     operands are latched at acceptance and count is cleared. Start with any
//     other code causes no state change.
//   - MUL: acc[2W-1:0] = {0, multiplier}. Each cycle: if acc[0], add the
//     multiplicand to acc[2W-1:W] with carry kept. Then shift acc right by 1.
//   - DIV: rem[W:0] is shifted left, taking in the next dividend bit (MSB
//     first). If rem >= divisor, subtract and shift in quotient bit 1; else 0.
//   - MUL/DIV advance count each cycle. At count==WIDTH-1 the next state is
//     DONE and hi/lo are written on that edge.
//   - DONE lasts exactly one cycle: done=1, busy=0. It returns to IDLE unless a
//     new start is accepted in that cycle.
//   Latency: start accepted on edge 0; busy high for cycles 1..WIDTH; hi/lo
//     updated and done=1 in cycle WIDTH+1. A hilo_rd in DONE reads new values.
//   Start while busy: not accepted. stall=1 holds the instruction in EX, and it
//     is accepted in the DONE cycle.
//   Divide by zero: lo={WIDTH{1'b1}}, hi=srca. Same latency; not an error.
//   Flush: if asserted in MUL/DIV, next state is IDLE and hi/lo keep their old
//     values. Flush beats a start in the same cycle. In IDLE/DONE, flush blocks
//     acceptance of a start.
//   Reset mid-operation: reset_n low overrides everything and returns to reset
//     values on the next edge.
//   Widths: the multiply product is full 2*WIDTH. Intermediate adders are
//     WIDTH+1 bits; no overflow is flagged.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined: signed (mult/div) semantics.
//     - Operand magnitudes are latched and the iteration runs on them.
//     - At the DONE write, the product is negated if sa^sb.
//     - The quotient is negated if sa^sb; the remainder takes the sign of srca.
//     - Div by zero skips the sign fix-up (lo=all ones, hi=srca).
//     - Latency is unchanged.
//   Undefined: unsigned (multu/divu) semantics, with no sign logic.
// TESTING
//   1 reset_n=0 for 2 cycles -> hi=lo=0, busy=stall=done=0.
//   2 mult 7 x 6 -> busy for cycles 1..32, done in cycle 33, hi=0, lo=42.
//   3 mult 0xFFFFFFFF x 0xFFFFFFFF (unsigned build) -> hi=0xFFFFFFFE, lo=1.
//   4 div 100/7 -> lo=14, hi=2. Div 5/0 -> lo=0xFFFFFFFF, hi=5.
//   5 hilo_rd=1 from cycle 2 to 33 during a mult -> stall=1 in cycles 2..32
//     and 0 in cycle 33. A back-to-back start is accepted in the DONE cycle.
//   6 flush in cycle 10 of a div, with hi/lo=0x11/0x22 beforehand -> IDLE in
//     cycle 11, no done pulse, hi/lo stay 0x11/0x22.
//   7 MULDIV_SIGNED_EN: -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     -100/7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for the EX-stage mult/div path.
//
// Runs a radix-2 shift-add multiply (ALU code 4'b1010) or a restoring divide
// (ALU code 4'b1011) over WIDTH cycles. It owns the HI/LO registers and stalls
// the pipeline while a HI/LO result is pending.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   -> signed mult/div. The iteration runs on operand magnitudes and
//                the sign is fixed up when HI/LO are written.
//   undefined -> unsigned multu/divu, with no sign logic.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   synchronous, active-low reset
//   start       in   EX holds a mult/div instruction this cycle
//   alucontrol  in   4'b1010 = mult, 4'b1011 = div, other codes ignored
//   srca        in   multiplicand / dividend
//   srcb        in   multiplier / divisor
//   hilo_rd     in   mfhi/mflo in EX
//   flush       in   kill the in-flight operation, or block a new start
//   busy        out  state is MUL or DIV
//   stall       out  busy & (start | hilo_rd), combinational
//   done        out  one-cycle pulse, HI/LO were written on the previous edge
//   hi, lo      out  HI/LO registers
//   dbg_state   out  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake: start is the request. Start is accepted on a rising edge when the
// FSM is in IDLE or DONE, flush is low and the code is mult or div. While
// busy, stall is high and the pipeline must hold the instruction (start stays
// asserted) until the DONE cycle, when it is accepted.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] OP_MULT = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {partial product, multiplier}
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;     // dividend bits out at top, quotient bits in at bottom
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 accept;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, rem_sub, rem_next;
    logic                 div_ge;
    logic [WIDTH-1:0]     quo_next;
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quo_res, rem_res;

`ifdef MULDIV_SIGNED_EN
    logic                 neg_q, neg_d;     // sa ^ sb
    logic                 rneg_q, rneg_d;   // remainder follows the dividend sign
    logic                 dvz_q, dvz_d;     // divide by zero
    logic [WIDTH-1:0]     srca_q, srca_d;   // raw dividend for the divide-by-zero result

    assign mag_a = srca[WIDTH-1] ? (-srca) : srca;
    assign mag_b = srcb[WIDTH-1] ? (-srcb) : srcb;
`else
    assign mag_a = srca;
    assign mag_b = srcb;
`endif

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush &&
                    ((alucontrol == OP_MULT) || (alucontrol == OP_DIV));

    // Shift-add step: the add keeps its carry in bit WIDTH, then the whole
    // 2*WIDTH+1 value shifts right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      {1'b0, mcand_q & {WIDTH{acc_q[0]}}};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step, dividend MSB first.
    assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_ge   = (rem_sh >= {1'b0, dvsr_q});
    assign rem_sub  = rem_sh - {1'b0, dvsr_q};
    assign rem_next = div_ge ? rem_sub : rem_sh;
    assign quo_next = {quo_q[WIDTH-2:0], div_ge};

    // With a zero divisor every step subtracts nothing and sets a quotient
    // bit, so the unsigned result is naturally lo=all ones, hi=dividend.
`ifdef MULDIV_SIGNED_EN
    always_comb begin
        prod_res = neg_q ? (-mul_next) : mul_next;
        quo_res  = neg_q ? (-quo_next) : quo_next;
        rem_res  = rneg_q ? (-rem_next[WIDTH-1:0]) : rem_next[WIDTH-1:0];
        if (dvz_q) begin
            quo_res = '1;
            rem_res = srca_q;
        end
    end
`else
    always_comb begin
        prod_res = mul_next;
        quo_res  = quo_next;
        rem_res  = rem_next[WIDTH-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dvz_d   = dvz_q;
        srca_d  = srca_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = (alucontrol == OP_MULT) ? S_MUL : S_DIV;
                    count_d = '0;
                    // Both datapaths are loaded; only the selected one iterates.
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvsr_d  = mag_b;
`ifdef MULDIV_SIGNED_EN
                    neg_d   = srca[WIDTH-1] ^ srcb[WIDTH-1];
                    rneg_d  = srca[WIDTH-1];
                    dvz_d   = (srcb == '0);
                    srca_d  = srca;
`endif
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_DONE;
                        count_d = '0;
                        hi_d    = prod_res[2*WIDTH-1:WIDTH];
                        lo_d    = prod_res[WIDTH-1:0];
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_next;
                    quo_d   = quo_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_DONE;
                        count_d = '0;
                        hi_d    = rem_res;
                        lo_d    = quo_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
            srca_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
            srca_q  <= srca_d;
`endif
        end
    end

    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign stall     = busy && (start || hilo_rd);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed test bench for muldiv_ctrl (WIDTH=32).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// after that, away from the active edge.
module tb_muldiv_ctrl;
    localparam int W = 32;
    localparam logic [3:0] OP_MULT = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   alucontrol;
    logic [W-1:0] srca, srcb;
    logic         hilo_rd;
    logic         flush;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic seen_done;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .alucontrol(alucontrol),
        .srca(srca), .srcb(srcb), .hilo_rd(hilo_rd), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation from idle: start in cycle 0, busy in cycles 1..32,
    // done with the result in cycle 33, idle again in cycle 34.
    task automatic run_op(input string tag, input logic [3:0] code,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        start = 1'b1; alucontrol = code; srca = a; srcb = b;
        tick();
        start = 1'b0;
        #1;
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_stall_c1"}, stall, 0);
        repeat (31) tick();
        chk({tag, "_busy_c32"}, busy, 1);
        chk({tag, "_done_c32"}, done, 0);
        tick();
        chk({tag, "_done_c33"}, done, 1);
        chk({tag, "_busy_c33"}, busy, 0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        tick();
        chk({tag, "_done_c34"}, done, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; alucontrol = 4'b0000;
        srca = '0; srcb = '0; hilo_rd = 1'b0; flush = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        // Basic multiply
        run_op("mul7x6", OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42);

        // All-ones multiply
`ifdef MULDIV_SIGNED_EN
        run_op("mulm1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
`else
        run_op("mulmax", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
`endif

        // Divide, including divide by zero
        run_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

        // Start with a non mult/div code is ignored
        start = 1'b1; alucontrol = 4'b0010; srca = 32'd3; srcb = 32'd4;
        tick();
        start = 1'b0;
        #1;
        chk("badcode_busy", busy, 0);
        chk("badcode_state", dbg_state, 0);

        // Stall from hilo_rd and a held start, back-to-back acceptance in DONE
        start = 1'b1; alucontrol = OP_MULT; srca = 32'd9; srcb = 32'd11;
        tick();                                   // cycle 1
        start = 1'b0;
        #1;
        chk("b2b_stall_c1", stall, 0);
        tick();                                   // cycle 2
        hilo_rd = 1'b1; start = 1'b1; srca = 32'd3; srcb = 32'd5;
        #1;
        chk("b2b_stall_c2", stall, 1);
        repeat (30) tick();                       // cycle 32
        chk("b2b_stall_c32", stall, 1);
        chk("b2b_busy_c32", busy, 1);
        tick();                                   // cycle 33
        chk("b2b_done_c33", done, 1);
        chk("b2b_stall_c33", stall, 0);
        chk("b2b_lo1", lo, 32'd99);
        chk("b2b_hi1", hi, 32'd0);
        tick();                                   // cycle 34: second op running
        start = 1'b0; hilo_rd = 1'b0;
        #1;
        chk("b2b_busy_c34", busy, 1);
        chk("b2b_state_c34", dbg_state, 1);
        chk("b2b_lo_hold", lo, 32'd99);
        repeat (32) tick();                       // cycle 66
        chk("b2b_done2", done, 1);
        chk("b2b_lo2", lo, 32'd15);
        chk("b2b_hi2", hi, 32'd0);
        tick();

        // Flush mid-divide keeps HI/LO
        run_op("div451_20", OP_DIV, 32'h451, 32'h20, 32'h11, 32'h22);
        start = 1'b1; alucontrol = OP_DIV; srca = 32'd1000; srcb = 32'd3;
        tick();                                   // cycle 1
        start = 1'b0;
        repeat (9) tick();                        // cycle 10
        flush = 1'b1;
        #1;
        chk("flush_state_c10", dbg_state, 2);
        tick();                                   // cycle 11
        flush = 1'b0;
        chk("flush_busy_c11", busy, 0);
        chk("flush_done_c11", done, 0);
        chk("flush_state_c11", dbg_state, 0);
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);
        seen_done = 1'b0;
        repeat (30) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("flush_no_done", seen_done, 0);
        chk("flush_hi_late", hi, 32'h11);
        chk("flush_lo_late", lo, 32'h22);

        // Flush blocks a start in IDLE
        flush = 1'b1; start = 1'b1; alucontrol = OP_MULT; srca = 32'd2; srcb = 32'd2;
        tick();
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush_blk_busy", busy, 0);
        chk("flush_blk_state", dbg_state, 0);

`ifdef MULDIV_SIGNED_EN
        run_op("smul", OP_MULT, -32'sd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("sdiv", OP_DIV, -32'sd100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
        run_op("sdiv0", OP_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
`endif

        // Reset mid-operation
        start = 1'b1; alucontrol = OP_MULT; srca = 32'd7; srcb = 32'd6;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_state", dbg_state, 0);
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        seen_done = 1'b0;
        repeat (35) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("mrst_no_done", seen_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
